sif_rx: RTL
===========

# sif_rx

Serial-interface receiver: the far-end counterpart of the sif transmitter. Recovers 8-bit words from the three-wire sck/sdat/sen link and presents each completed word with a one-cycle valid strobe. Detects truncated and over-long frames. Sits on the register/control side of a peripheral that is programmed over the sif link.

## Interface
Parameters:
- SIF_BITS, 8, bits per frame; fixed at 8 in this revision.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- sck  input  1  serial clock from transmitter; idles low.
- sdat  input  1  serial data, LSB first; changes on the same clk edge that raises sck.
- sen  input  1  frame enable, active high.
- data  output  8  last good word; reset 8'h00; holds until next good word.
- valid  output  1  one-cycle strobe, data updated this cycle; reset 0.
- frame_err  output  1  one-cycle strobe on a bad frame; reset 0.
- busy  output  1  high while in RECV or DONE; reset 0.

## Operation
- sck, sdat, sen pass through identical input pipelines (see Configuration), giving sck_s, sdat_s, sen_s. One further register on sck_s gives sck_d. Rise = sck_s & ~sck_d.
- Bits are sampled on sck rise: sdat_s in the rise cycle is the bit. Bit 0 first. Shift register fills from MSB downward so bit 7 lands in data[7].
- 4-bit bit counter cnt, range 0..8. Clears on IDLE->RECV.
- FSM states: WAIT, IDLE, RECV, DONE. Reset state WAIT.
  - WAIT: ignore sck; sen_s low -> IDLE. No strobes.
  - IDLE: sen_s high -> RECV, cnt=0.
  - RECV: each rise shifts a bit, cnt+1. On the rise with cnt==7, load data, pulse valid, go DONE. sen_s low with cnt 1..7 -> pulse frame_err, data unchanged, go IDLE. sen_s low with cnt 0 -> IDLE silently.
  - DONE: sen_s low -> IDLE. Any rise -> pulse frame_err (overrun), go WAIT.
- Same-cycle rise and sen_s low in RECV: rise processed first. If it completes bit 7, then valid, no error, go IDLE. Otherwise frame_err, go IDLE.
- Reset mid-frame: all state cleared. WAIT ensures a frame in progress at reset release is discarded; the next full frame after sen low is received normally.
- valid and frame_err are never high in the same cycle.

## Timing
- T = clk edge on which transmitter drives the 8th sck rise.
- With SIF_RX_SYNC_EN: data/valid update at edge T+3; valid high for one cycle.
- Without it: update at edge T+1.
- frame_err for truncation follows the same latency, measured from the edge that lowers sen.
- Minimum sck high and low time: 1 clk. sdat/sck/sen skew at pins: less than 1 clk.
- Back-to-back frames: sen low for at least 1 clk between frames. The receiver must accept them.

## Configuration
- SIF_RX_SYNC_EN defined: each input passes through a 2-flop synchronizer (reset 0); asynchronous transmitter clock supported; latency 3.
- Undefined: inputs used directly; transmitter must share clk; latency 1. FSM behaviour identical.

## Structure
- Package sif_pkg: SIF_BITS constant, FSM state encoding (WAIT, IDLE, RECV, DONE), sync depth constant (2).
- Sub-module sif_sync: single-bit N-stage synchronizer with async active-low reset. Instantiated for sck, sdat and sen under SIF_RX_SYNC_EN; a wire otherwise.

## Test plan
- Frame 0xA5, sck toggling every clk (transmitter-style) -> data=0xA5, one valid pulse at T+3 (sync) / T+1 (no sync), frame_err 0, busy low after sen falls.
- Back-to-back 0x3C then 0xC3, 1 clk sen gap -> two valid pulses, data 0x3C then 0xC3.
- sen dropped after 5 bits of 0xFF -> one frame_err pulse, no valid, data keeps previous value.
- 9 sck rises in one frame of 0x81 -> valid with data=0x81, then frame_err on the 9th rise, then recovery on the next frame 0x42.
- rst asserted after 3 bits, released with sen still high -> no strobes until sen low; next frame 0x5A received correctly.
- Slow sck (4 clk per half period), frame 0x01 -> data=0x01, single valid pulse.

Source files
------------

// File: rtl/sif_pkg.sv
// Shared constants and FSM encoding for the sif serial receiver.
package sif_pkg;

    localparam int SIF_BITS   = 8;
    localparam int SYNC_DEPTH = 2;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_IDLE = 2'd1,
        S_RECV = 2'd2,
        S_DONE = 2'd3
    } sif_state_e;

endpackage

// File: rtl/sif_sync.sv
// Single-bit N-stage synchronizer, async active-low reset, output resets to 0.
module sif_sync
    import sif_pkg::*;
#(
    parameter int STAGES = SYNC_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sif_rx.sv
// sif three-wire receiver: recovers LSB-first 8-bit words, flags truncated/over-long frames.
// Define SIF_RX_SYNC_EN to put 2-flop synchronizers on sck/sdat/sen (latency 3 instead of 1).
module sif_rx #(
    parameter int SIF_BITS = sif_pkg::SIF_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sck,
    input  logic                sdat,
    input  logic                sen,
    output logic [SIF_BITS-1:0] data,
    output logic                valid,
    output logic                frame_err,
    output logic                busy
);
    import sif_pkg::*;

    logic sck_s;
    logic sdat_s;
    logic sen_s;
    logic in_ready;

`ifdef SIF_RX_SYNC_EN
    sif_sync #(.STAGES(SYNC_DEPTH)) u_sync_sck  (.clk(clk), .rst(rst), .d(sck),  .q(sck_s));
    sif_sync #(.STAGES(SYNC_DEPTH)) u_sync_sdat (.clk(clk), .rst(rst), .d(sdat), .q(sdat_s));
    sif_sync #(.STAGES(SYNC_DEPTH)) u_sync_sen  (.clk(clk), .rst(rst), .d(sen),  .q(sen_s));
    // Synchronizers read 0 until filled; hold WAIT until real sen is visible.
    sif_sync #(.STAGES(SYNC_DEPTH)) u_sync_rdy  (.clk(clk), .rst(rst), .d(1'b1), .q(in_ready));
`else
    assign sck_s    = sck;
    assign sdat_s   = sdat;
    assign sen_s    = sen;
    assign in_ready = 1'b1;
`endif

    sif_state_e          state_q, state_d;
    logic                sck_dly_q, sck_dly_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SIF_BITS-1:0] shift_q, shift_d;
    logic [SIF_BITS-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                frame_err_q, frame_err_d;
    logic                rise;
    logic                last_bit;

    assign rise     = sck_s & ~sck_dly_q;
    assign last_bit = rise && (cnt_q == CNT_W'(SIF_BITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // A rise is always handled before a same-cycle sen drop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: if (in_ready && !sen_s) state_d = S_IDLE;
            S_IDLE: if (sen_s) state_d = S_RECV;
            S_RECV: begin
                if (last_bit) begin
                    state_d = sen_s ? S_DONE : S_IDLE;
                end else if (!sen_s) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (rise) begin
                    state_d = S_WAIT;
                end else if (!sen_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        sck_dly_d   = sck_s;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: if (sen_s) cnt_d = '0;
            S_RECV: begin
                if (rise) begin
                    shift_d = {sdat_s, shift_q[SIF_BITS-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                end
                if (last_bit) begin
                    data_d  = shift_d;
                    valid_d = 1'b1;
                end else if (!sen_s && (rise || cnt_q != '0)) begin
                    frame_err_d = 1'b1;
                end
            end
            S_DONE: if (rise) frame_err_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_dly_q   <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sck_dly_q   <= sck_dly_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == S_RECV) || (state_q == S_DONE);

endmodule
